riscv_dp_wb_arb: RTL and testbench



---
 rtl/riscv_dp_wb_arb.sv | 117 +++++++++++
 tb/tb_riscv_dp_wb_arb.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dp_wb_arb.sv
// Writeback arbiter: merges pipeline writes and buffered long-latency results onto one
// registered register-file write port, and tracks registers with pending long-latency writes.
module riscv_dp_wb_arb #(
    parameter int unsigned MP_DATA_WIDTH = 32,
    parameter int unsigned MP_ADDR_WIDTH = 5,
    parameter int unsigned MP_FIFO_DEPTH = 2
) (
    input  logic                                 iclk,
    input  logic                                 irst,
    input  logic                                 ipwen,
    input  logic [MP_ADDR_WIDTH-1:0]             ipa,
    input  logic [MP_DATA_WIDTH-1:0]             ipwdata,
    input  logic                                 ilvalid,
    input  logic [MP_ADDR_WIDTH-1:0]             ila,
    input  logic [MP_DATA_WIDTH-1:0]             ilwdata,
    output logic                                 olready,
    input  logic                                 iissue_valid,
    input  logic [MP_ADDR_WIDTH-1:0]             iissue_rd,
    input  logic [MP_ADDR_WIDTH-1:0]             ia1,
    input  logic [MP_ADDR_WIDTH-1:0]             ia2,
    output logic                                 obusy1,
    output logic                                 obusy2,
    output logic                                 owen3,
    output logic [MP_ADDR_WIDTH-1:0]             oa3,
    output logic [MP_DATA_WIDTH-1:0]             owdata3,
    output logic [$clog2(MP_FIFO_DEPTH):0]       ocount
);

    localparam int unsigned LP_PTR_W = $clog2(MP_FIFO_DEPTH);
    localparam int unsigned LP_CNT_W = LP_PTR_W + 1;
    localparam int unsigned LP_NREG  = 2 ** MP_ADDR_WIDTH;
    localparam logic [LP_CNT_W-1:0] LP_FULL = LP_CNT_W'(MP_FIFO_DEPTH);

    logic [MP_ADDR_WIDTH-1:0] r_fifo_a [MP_FIFO_DEPTH];
    logic [MP_DATA_WIDTH-1:0] r_fifo_d [MP_FIFO_DEPTH];
    logic [LP_PTR_W-1:0]      r_wr_ptr;
    logic [LP_PTR_W-1:0]      r_rd_ptr;
    logic [LP_CNT_W-1:0]      r_count;
    logic [LP_NREG-1:0]       r_busy;
    logic                     r_wen3;
    logic [MP_ADDR_WIDTH-1:0] r_a3;
    logic [MP_DATA_WIDTH-1:0] r_wdata3;

    logic                     w_ready;
    logic                     w_push;
    logic                     w_pipe;
    logic                     w_pop;
    logic [MP_ADDR_WIDTH-1:0] w_head_a;
    logic [MP_DATA_WIDTH-1:0] w_head_d;

    // Readiness comes from registered occupancy only, so a full buffer never pops through.
    assign w_ready  = (r_count < LP_FULL);
    assign w_push   = ilvalid && w_ready && (ila != '0);
    assign w_pipe   = ipwen && (ipa != '0);
    assign w_pop    = !w_pipe && (r_count != '0);
    assign w_head_a = r_fifo_a[r_rd_ptr];
    assign w_head_d = r_fifo_d[r_rd_ptr];

    always_ff @(posedge iclk) begin
        if (w_push) begin
            r_fifo_a[r_wr_ptr] <= ila;
            r_fifo_d[r_wr_ptr] <= ilwdata;
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_busy   <= '0;
            r_wen3   <= 1'b0;
            r_a3     <= '0;
            r_wdata3 <= '0;
        end else begin
            if (w_pipe) begin
                r_wen3   <= 1'b1;
                r_a3     <= ipa;
                r_wdata3 <= ipwdata;
            end else if (w_pop) begin
                r_wen3   <= 1'b1;
                r_a3     <= w_head_a;
                r_wdata3 <= w_head_d;
                r_rd_ptr <= r_rd_ptr + LP_PTR_W'(1);
            end else begin
                r_wen3   <= 1'b0;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_W'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LP_CNT_W'(1);
                2'b01:   r_count <= r_count - LP_CNT_W'(1);
                default: r_count <= r_count;
            endcase

            // The issue set is written last so it overrides a same-edge pop clear.
            if (w_pop) begin
                r_busy[w_head_a] <= 1'b0;
            end
            if (iissue_valid && (iissue_rd != '0)) begin
                r_busy[iissue_rd] <= 1'b1;
            end
        end
    end

    assign olready = w_ready;
    assign obusy1  = (ia1 != '0) && r_busy[ia1];
    assign obusy2  = (ia2 != '0) && r_busy[ia2];
    assign owen3   = r_wen3;
    assign oa3     = r_a3;
    assign owdata3 = r_wdata3;
    assign ocount  = r_count;

endmodule

// File: tb/tb_riscv_dp_wb_arb.sv
// Self-checking bench for riscv_dp_wb_arb: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the writeback arbiter.
module tb_riscv_dp_wb_arb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;

    logic          iclk = 1'b0;
    logic          irst;
    logic          ipwen;
    logic [AW-1:0] ipa;
    logic [DW-1:0] ipwdata;
    logic          ilvalid;
    logic [AW-1:0] ila;
    logic [DW-1:0] ilwdata;
    logic          olready;
    logic          iissue_valid;
    logic [AW-1:0] iissue_rd;
    logic [AW-1:0] ia1;
    logic [AW-1:0] ia2;
    logic          obusy1;
    logic          obusy2;
    logic          owen3;
    logic [AW-1:0] oa3;
    logic [DW-1:0] owdata3;
    logic [$clog2(DEPTH):0] ocount;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } entry_t;

    entry_t              mQueue[$];
    logic [2**AW-1:0]    mBusy;
    logic                mWen;
    logic [AW-1:0]       mA;
    logic [DW-1:0]       mD;

    always #5 iclk = ~iclk;

    riscv_dp_wb_arb #(
        .MP_DATA_WIDTH(DW),
        .MP_ADDR_WIDTH(AW),
        .MP_FIFO_DEPTH(DEPTH)
    ) dut (
        .iclk(iclk),
        .irst(irst),
        .ipwen(ipwen),
        .ipa(ipa),
        .ipwdata(ipwdata),
        .ilvalid(ilvalid),
        .ila(ila),
        .ilwdata(ilwdata),
        .olready(olready),
        .iissue_valid(iissue_valid),
        .iissue_rd(iissue_rd),
        .ia1(ia1),
        .ia2(ia2),
        .obusy1(obusy1),
        .obusy2(obusy2),
        .owen3(owen3),
        .oa3(oa3),
        .owdata3(owdata3),
        .ocount(ocount)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic clearInputs();
        irst         = 1'b0;
        ipwen        = 1'b0;
        ipa          = '0;
        ipwdata      = '0;
        ilvalid      = 1'b0;
        ila          = '0;
        ilwdata      = '0;
        iissue_valid = 1'b0;
        iissue_rd    = '0;
        ia1          = '0;
        ia2          = '0;
    endtask

    task automatic applyStimulus();
        irst         = ($urandom_range(0, 99) == 0);
        ipwen        = ($urandom_range(0, 2) == 0);
        ipa          = AW'($urandom_range(0, 7));
        ipwdata      = $urandom;
        ilvalid      = ($urandom_range(0, 1) == 1);
        ila          = AW'($urandom_range(0, 7));
        ilwdata      = $urandom;
        iissue_valid = ($urandom_range(0, 2) == 0);
        iissue_rd    = AW'($urandom_range(0, 7));
        ia1          = AW'($urandom_range(0, 7));
        ia2          = AW'($urandom_range(0, 7));
    endtask

    // Reference behaviour for one rising edge, using the inputs currently applied.
    task automatic modelEdge();
        bit     accept;
        entry_t e;
        if (irst) begin
            mQueue.delete();
            mBusy = '0;
            mWen  = 1'b0;
            mA    = '0;
            mD    = '0;
        end else begin
            accept = ilvalid && (mQueue.size() < DEPTH);
            if (ipwen && ipa != 0) begin
                mWen = 1'b1;
                mA   = ipa;
                mD   = ipwdata;
            end else if (mQueue.size() > 0) begin
                e    = mQueue.pop_front();
                mWen = 1'b1;
                mA   = e.a;
                mD   = e.d;
                mBusy[e.a] = 1'b0;
            end else begin
                mWen = 1'b0;
            end
            if (accept && ila != 0) begin
                e.a = ila;
                e.d = ilwdata;
                mQueue.push_back(e);
            end
            if (iissue_valid && iissue_rd != 0) mBusy[iissue_rd] = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge iclk);
        modelEdge();
        #1;
        checkOutput("owen3", owen3, mWen);
        checkOutput("oa3", oa3, mA);
        checkOutput("owdata3", owdata3, mD);
        checkOutput("ocount", ocount, mQueue.size());
        checkOutput("olready", olready, mQueue.size() < DEPTH);
        checkOutput("obusy1", obusy1, (ia1 != 0) && mBusy[ia1]);
        checkOutput("obusy2", obusy2, (ia2 != 0) && mBusy[ia2]);
    endtask

    initial begin
        mBusy = '0;
        mWen  = 1'b0;
        mA    = '0;
        mD    = '0;
        clearInputs();
        irst = 1'b1;
        step();
        step();
        clearInputs();
        checkOutput("reset_owen3", owen3, 0);
        checkOutput("reset_ocount", ocount, 0);
        checkOutput("reset_olready", olready, 1);

        ipwen = 1'b1; ipa = 5; ipwdata = 32'hDEADBEEF;
        step();
        checkOutput("pipe_wen", owen3, 1);
        checkOutput("pipe_a", oa3, 5);
        checkOutput("pipe_d", owdata3, 32'hDEADBEEF);
        clearInputs();
        step();
        checkOutput("idle_wen", owen3, 0);
        checkOutput("idle_hold_a", oa3, 5);

        iissue_valid = 1'b1; iissue_rd = 7; ia1 = 7;
        step();
        checkOutput("busy7_set", obusy1, 1);
        iissue_valid = 1'b0; ilvalid = 1'b1; ila = 7; ilwdata = 32'h11;
        step();
        checkOutput("busy7_held", obusy1, 1);
        checkOutput("ll_not_yet", owen3, 0);
        ilvalid = 1'b0;
        step();
        checkOutput("ll_wen", owen3, 1);
        checkOutput("ll_a", oa3, 7);
        checkOutput("ll_d", owdata3, 32'h11);
        checkOutput("busy7_clr", obusy1, 0);
        clearInputs();

        ipwen = 1'b1; ipa = 10; ipwdata = 32'h1010;
        ilvalid = 1'b1; ila = 1; ilwdata = 32'hA1;
        step();
        ila = 2; ilwdata = 32'hA2;
        step();
        checkOutput("full_cnt", ocount, 2);
        checkOutput("full_rdy", olready, 0);
        ila = 3; ilwdata = 32'hA3;
        step();
        checkOutput("held_cnt", ocount, 2);
        checkOutput("held_pipe_a", oa3, 10);
        ipwen = 1'b0;
        step();
        checkOutput("order1", oa3, 1);
        step();
        checkOutput("order2", oa3, 2);
        ilvalid = 1'b0;
        step();
        checkOutput("order3", oa3, 3);
        checkOutput("order3_d", owdata3, 32'hA3);
        checkOutput("drained", ocount, 0);
        clearInputs();

        ipwen = 1'b1; ipa = 12; ipwdata = 32'hC;
        ilvalid = 1'b1; ila = 4; ilwdata = 32'h44;
        step();
        ilvalid = 1'b0; ipa = 0; ipwdata = 32'hBAD;
        step();
        checkOutput("pa0_wen", owen3, 1);
        checkOutput("pa0_a", oa3, 4);
        checkOutput("pa0_d", owdata3, 32'h44);
        clearInputs();

        ipwen = 1'b1; ipa = 12; ilvalid = 1'b1; ila = 9; ilwdata = 32'h99;
        step();
        ipwen = 1'b0; ilvalid = 1'b0; iissue_valid = 1'b1; iissue_rd = 9; ia2 = 9;
        step();
        checkOutput("setwin_a", oa3, 9);
        checkOutput("setwin_busy", obusy2, 1);
        iissue_valid = 1'b0;
        step();
        checkOutput("setwin_keep", obusy2, 1);
        clearInputs();

        ipwen = 1'b1; ipa = 12; ilvalid = 1'b1; ila = 1;
        iissue_valid = 1'b1; iissue_rd = 3;
        step();
        ila = 2; iissue_rd = 5; ia1 = 3; ia2 = 5;
        step();
        checkOutput("prerst_cnt", ocount, 2);
        checkOutput("prerst_b1", obusy1, 1);
        irst = 1'b1;
        step();
        checkOutput("rst_cnt", ocount, 0);
        checkOutput("rst_wen", owen3, 0);
        checkOutput("rst_b1", obusy1, 0);
        checkOutput("rst_b2", obusy2, 0);
        checkOutput("rst_rdy", olready, 1);
        clearInputs();
        step();

        for (int i = 0; i < 3000; i++) begin
            applyStimulus();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
